// File: rtl/reg_out.sv
// SAP-1 output register: captures the bus on load and drives binary, BCD and
// three-digit seven-segment views of the held value.
module reg_out #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bus,
  output logic [7:0] out,
  output logic       updated,
  output logic [3:0] dec_hund,
  output logic [3:0] dec_tens,
  output logic [3:0] dec_ones,
  output logic [6:0] seg_hund,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BCD_W  = 12;
  localparam logic [6:0]  SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [BCD_W-1:0] bcd;
  logic [6:0]       raw_hund;
  logic [6:0]       raw_tens;
  logic [6:0]       raw_ones;
  logic             blank_hund;
  logic             blank_tens;

  // Active-high {g,f,e,d,c,b,a} pattern; codes above 9 are dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Capture register; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= 8'h00;
      updated <= 1'b0;
    end else begin
      if (load) begin
        out <= bus;
      end
      updated <= load;
    end
  end

  // Double dabble; the hundreds digit never exceeds 2 so it needs no correction.
  always_comb begin
    bcd = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
      bcd = {bcd[BCD_W-2:0], out[i]};
    end
  end

  assign dec_hund = bcd[11:8];
  assign dec_tens = bcd[7:4];
  assign dec_ones = bcd[3:0];

  assign raw_hund   = seg_decode(dec_hund);
  assign raw_tens   = seg_decode(dec_tens);
  assign raw_ones   = seg_decode(dec_ones);
  assign blank_hund = (dec_hund == 4'd0);
  assign blank_tens = blank_hund && (dec_tens == 4'd0);

  // Leading-zero blanking first, then optional polarity inversion.
  assign seg_hund = (blank_hund ? 7'b0000000 : raw_hund) ^ SEG_INV;
  assign seg_tens = (blank_tens ? 7'b0000000 : raw_tens) ^ SEG_INV;
  assign seg_ones = raw_ones ^ SEG_INV;

endmodule

// File: tb/tb_reg_out.sv
// Bench for reg_out: directed vector table, a bus-isolation check, a random
// run against an arithmetic reference model, and a full 0-255 sweep.
module tb_reg_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] bus;

  logic [7:0] out_h, out_l;
  logic       upd_h, upd_l;
  logic [3:0] dh_h, dt_h, do_h, dh_l, dt_l, do_l;
  logic [6:0] sh_h, st_h, so_h, sh_l, st_l, so_l;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_out;
  logic       m_upd;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] bus;
    logic [7:0] exp_out;
    logic       exp_upd;
  } vec_t;

  vec_t tbl[12];

  logic [6:0] seg_tbl[10];

  reg_out #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .load(load), .bus(bus),
    .out(out_h), .updated(upd_h),
    .dec_hund(dh_h), .dec_tens(dt_h), .dec_ones(do_h),
    .seg_hund(sh_h), .seg_tens(st_h), .seg_ones(so_h)
  );

  reg_out #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .load(load), .bus(bus),
    .out(out_l), .updated(upd_l),
    .dec_hund(dh_l), .dec_tens(dt_l), .dec_ones(do_l),
    .seg_hund(sh_l), .seg_tens(st_l), .seg_ones(so_l)
  );

  always #5 clk = ~clk;

  // Compare every output of both instances against the value expected in out.
  task automatic check(input string name, input logic [7:0] e_out, input logic e_upd);
    int v;
    logic [11:0] e_dig;
    logic [20:0] e_seg;
    logic [6:0]  s_h, s_t, s_o;
    v = int'(e_out);
    e_dig = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    s_h = (v / 100 == 0) ? 7'h00 : seg_tbl[v / 100];
    s_t = (v < 10) ? 7'h00 : seg_tbl[(v / 10) % 10];
    s_o = seg_tbl[v % 10];
    e_seg = {s_h, s_t, s_o};
    n_vec++;
    if (out_h !== e_out || out_l !== e_out) begin
      n_err++;
      $display("FAIL %s out: got %h/%h expected %h", name, out_h, out_l, e_out);
    end
    if (upd_h !== e_upd || upd_l !== e_upd) begin
      n_err++;
      $display("FAIL %s updated: got %b/%b expected %b", name, upd_h, upd_l, e_upd);
    end
    if ({dh_h, dt_h, do_h} !== e_dig || {dh_l, dt_l, do_l} !== e_dig) begin
      n_err++;
      $display("FAIL %s digits: got %h/%h expected %h", name,
               {dh_h, dt_h, do_h}, {dh_l, dt_l, do_l}, e_dig);
    end
    if ({sh_h, st_h, so_h} !== e_seg) begin
      n_err++;
      $display("FAIL %s seg_active_high: got %b expected %b", name, {sh_h, st_h, so_h}, e_seg);
    end
    if ({sh_l, st_l, so_l} !== ~e_seg) begin
      n_err++;
      $display("FAIL %s seg_active_low: got %b expected %b", name, {sh_l, st_l, so_l}, ~e_seg);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] b);
    rst  = r;
    load = l;
    bus  = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'h55, 8'hFF, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h99, 8'hFF, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h77, 8'h77, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'hAA, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'hAA, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'hAA, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};

    rst  = 1'b0;
    load = 1'b0;
    bus  = 8'h00;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].load, tbl[i].bus);
      check($sformatf("tbl%0d", i), tbl[i].exp_out, tbl[i].exp_upd);
    end

    // Loaded value must not follow the bus between edges.
    step(1'b0, 1'b1, 8'h64);
    check("load_64", 8'h64, 1'b1);
    bus = 8'h09;
    #3;
    check("bus_isolation", 8'h64, 1'b1);
    step(1'b0, 1'b0, 8'h09);
    check("pulse_drop", 8'h64, 1'b0);

    // Random run against the behavioural model.
    m_out = 8'h64;
    m_upd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic r, l;
      logic [7:0] b;
      r = ($urandom_range(0, 15) == 0);
      l = $urandom_range(0, 1) == 1;
      b = 8'($urandom_range(0, 255));
      step(r, l, b);
      if (r) m_out = 8'h00;
      else if (l) m_out = b;
      m_upd = !r && l;
      check($sformatf("rand%0d", i), m_out, m_upd);
    end

    // Full sweep with load held high: one captured value per edge.
    for (int v = 0; v < 256; v++) begin
      step(1'b0, 1'b1, 8'(v));
      check($sformatf("sweep%0d", v), 8'(v), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_out.md
REG_OUT -- requirements
Module: reg_out

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 0, meaning: 0 = segment outputs active-high, 1 = all segment bits inverted.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load  input  1  capture enable; when high, bus is latched into out at the next rising clk.
REQ-005 bus  input  8  data from the shared SAP-1 bus (accumulator value during the OUT instruction).
REQ-006 out  output  8  registered output value (binary).
REQ-007 updated  output  1  one-cycle pulse, registered, high in the cycle after a load capture.
REQ-008 dec_hund  output  4  BCD hundreds digit of out, range 0-2.
REQ-009 dec_tens  output  4  BCD tens digit of out, range 0-9.
REQ-010 dec_ones  output  4  BCD ones digit of out, range 0-9.
REQ-011 seg_hund, seg_tens, seg_ones  output  7 each  seven-segment patterns for the three digits; bit order {g,f,e,d,c,b,a}.

Function
REQ-012 On a rising clk with rst=1, out SHALL become 8'h00 and updated SHALL become 0, regardless of load or bus.
REQ-013 On a rising clk with rst=0 and load=1, out SHALL take the value of bus; latency is one clock edge.
REQ-014 On a rising clk with rst=0 and load=0, out SHALL hold its previous value; bus changes are ignored.
REQ-015 rst SHALL take priority over load when both are high on the same edge.
REQ-016 out SHALL change only on rising clk edges; there is no combinational path from bus to out.
REQ-017 When load is held high across consecutive edges, out SHALL track bus on every edge, one value per edge.
REQ-018 updated SHALL be 1 for exactly the cycle following each edge where rst=0 and load=1, and 0 otherwise.
REQ-019 dec_hund/dec_tens/dec_ones SHALL be a purely combinational unsigned binary-to-BCD conversion of out (0-255), so that 100*hund + 10*tens + ones = out.
REQ-020 The BCD conversion SHALL use shift-add-3 (double dabble) or an equivalent method; no multiply or divide operators.
REQ-021 Segment decode for digits 0-9, active-high {g..a}, SHALL be:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
REQ-022 Digit codes 10-15 on the decoder input SHALL produce all segments off.
REQ-023 seg_hund SHALL blank (all segments off) when dec_hund=0.
REQ-024 seg_tens SHALL blank when dec_hund=0 and dec_tens=0.
REQ-025 seg_ones SHALL never blank, so value 0 displays a single "0".
REQ-026 SEG_ACTIVE_LOW=1 SHALL invert all 21 segment bits after blanking is applied.

Reset
REQ-027 Reset is synchronous: out, updated and all derived outputs SHALL reflect value 0 after the first rising clk with rst=1, and remain there while rst stays high.
REQ-028 Reset mid-operation SHALL discard the held value; the first load after rst deasserts SHALL capture normally.
REQ-029 Before the first reset edge, output values are undefined; no initial-value dependence is permitted.

Verification
REQ-030 rst=1 for one edge -> out=00, updated=0, seg_ones shows "0", seg_tens and seg_hund blank.
REQ-031 load=1, bus=2A, edge -> out=2A, updated=1 for one cycle, digits 0/4/2; then bus=FF, edge -> out=FF, digits 2/5/5.
REQ-032 load=0, bus=55 then bus=99 over two edges -> out stays FF, updated=0.
REQ-033 load=1, bus=3C, edge -> out=3C; then rst=1, edge -> out=00; then rst=0, load=1, bus=77, edge -> out=77.
REQ-034 rst=1 and load=1 with bus=AA on the same edge -> out=00.
REQ-035 Sweep bus 0-255 with load=1 -> every value's BCD digits and segment patterns match the arithmetic values for SEG_ACTIVE_LOW=0 and SEG_ACTIVE_LOW=1.
